// File: rtl/m_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : m_frame_tx
//  Purpose  : Master-side frame transmitter for the serial host link.
//             Sends marker, status, command, N, N payload bytes, CRC high and
//             CRC low over a valid/ready byte handshake, reading payload from a
//             synchronous buffer and driving the shared external CRC engine.
//  Options  : M_FRAME_TX_TIMEOUT_EN - abandon a frame when the serializer
//             stalls a byte for TIMEOUT cycles (timeout_err tied 0 otherwise).
//  Revision : 1.0 - initial release
// ============================================================================
module m_frame_tx #(
    parameter logic [7:0] MARKER  = 8'hA5,
    parameter int         TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [7:0]  sts_in,
    input  logic [7:0]  cmd_in,
    input  logic [7:0]  len_in,
    output logic        pl_rd,
    output logic [7:0]  pl_addr,
    input  logic [7:0]  pl_data,
    output logic [7:0]  tx_d,
    output logic        tx_d_vld,
    input  logic        tx_d_rdy,
    input  logic [15:0] crc,
    output logic        crc_update,
    output logic        crc_rst,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_MRK      = 4'd1,
        S_STS      = 4'd2,
        S_CMD      = 4'd3,
        S_LEN      = 4'd4,
        S_FETCH    = 4'd5,
        S_DATA     = 4'd6,
        S_CRC_WAIT = 4'd7,
        S_CRC_H    = 4'd8,
        S_CRC_L    = 4'd9,
        S_DONE     = 4'd10,
        S_TOUT     = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_sts;
    logic [7:0] r_cmd;
    logic [7:0] r_len;
    logic [7:0] r_addr;
    logic [7:0] r_pl_q;
    logic [7:0] r_crc_lo;
    logic       r_pl_fresh;
    logic       r_init_done;
    logic       r_init_crc_rst;
    logic       w_upd_state;
    logic       w_more;
    logic       w_timeout;

    // The wait counter is 10 bits wide, so the limit must fit in it.
    if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("m_frame_tx: TIMEOUT must be in 1..1023");
    end

    // Another payload byte follows when the next address is still below N.
    assign w_more  = ({1'b0, r_addr} + 9'd1) < {1'b0, r_len};
    assign pl_addr = r_addr;

`ifdef M_FRAME_TX_TIMEOUT_EN
    localparam logic [9:0] c_wait_last = 10'(TIMEOUT - 1);

    logic [9:0] r_wait;

    // Count consecutive stalled cycles of the byte on offer.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wait <= 10'd0;
        end else if (tx_d_vld && !tx_d_rdy) begin
            r_wait <= r_wait + 10'd1;
        end else begin
            r_wait <= 10'd0;
        end
    end

    // Fires in the stalled cycle that would take the count to TIMEOUT.
    assign w_timeout = tx_d_vld && !tx_d_rdy && (r_wait == c_wait_last);
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // One crc_rst pulse after reset release so the engine never keeps a partial CRC.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_init_done    <= 1'b0;
            r_init_crc_rst <= 1'b0;
        end else begin
            r_init_done    <= 1'b1;
            r_init_crc_rst <= ~r_init_done;
        end
    end

    // Frame header latches, payload address, payload hold and CRC low-byte hold.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sts      <= 8'd0;
            r_cmd      <= 8'd0;
            r_len      <= 8'd0;
            r_addr     <= 8'd0;
            r_pl_q     <= 8'd0;
            r_pl_fresh <= 1'b0;
            r_crc_lo   <= 8'd0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_sts <= sts_in;
                r_cmd <= cmd_in;
                r_len <= len_in;
            end
            if (r_state == S_LEN && tx_d_rdy) begin
                r_addr <= 8'd0;
            end
            if (r_state == S_FETCH) begin
                r_pl_fresh <= 1'b1;
            end
            if (r_state == S_DATA) begin
                // Hold the buffer word so tx_d stays put through a stall.
                if (r_pl_fresh) begin
                    r_pl_q     <= pl_data;
                    r_pl_fresh <= 1'b0;
                end
                // Only advance when another byte follows: the last fetch address is N-1.
                if (tx_d_rdy && w_more) begin
                    r_addr <= r_addr + 8'd1;
                end
            end
            if (r_state == S_CRC_H) begin
                r_crc_lo <= crc[7:0];
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_next      = r_state;
        tx_d        = 8'd0;
        tx_d_vld    = 1'b0;
        pl_rd       = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        crc_rst     = r_init_crc_rst;
        timeout_err = 1'b0;
        w_upd_state = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_MRK;
                end
            end
            S_MRK: begin
                tx_d        = MARKER;
                tx_d_vld    = 1'b1;
                w_upd_state = 1'b1;
                if (tx_d_rdy) w_next = S_STS;
            end
            S_STS: begin
                tx_d        = r_sts;
                tx_d_vld    = 1'b1;
                w_upd_state = 1'b1;
                if (tx_d_rdy) w_next = S_CMD;
            end
            S_CMD: begin
                tx_d        = r_cmd;
                tx_d_vld    = 1'b1;
                w_upd_state = 1'b1;
                if (tx_d_rdy) w_next = S_LEN;
            end
            S_LEN: begin
                tx_d        = r_len;
                tx_d_vld    = 1'b1;
                w_upd_state = 1'b1;
                if (tx_d_rdy) begin
                    w_next = (r_len == 8'd0) ? S_CRC_WAIT : S_FETCH;
                end
            end
            S_FETCH: begin
                pl_rd  = 1'b1;
                w_next = S_DATA;
            end
            S_DATA: begin
                tx_d        = r_pl_fresh ? pl_data : r_pl_q;
                tx_d_vld    = 1'b1;
                w_upd_state = 1'b1;
                if (tx_d_rdy) begin
                    w_next = w_more ? S_FETCH : S_CRC_WAIT;
                end
            end
            S_CRC_WAIT: begin
                w_next = S_CRC_H;
            end
            S_CRC_H: begin
                tx_d     = crc[15:8];
                tx_d_vld = 1'b1;
                if (tx_d_rdy) w_next = S_CRC_L;
            end
            S_CRC_L: begin
                tx_d     = r_crc_lo;
                tx_d_vld = 1'b1;
                if (tx_d_rdy) w_next = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                crc_rst = 1'b1;
                w_next  = S_IDLE;
            end
            S_TOUT: begin
                busy        = 1'b0;
                timeout_err = 1'b1;
                crc_rst     = 1'b1;
                w_next      = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase

        // A byte stalled for too long abandons the whole frame.
        if (w_timeout) begin
            w_next = S_TOUT;
        end
    end

    assign crc_update = tx_d_vld & tx_d_rdy & w_upd_state;

endmodule
`default_nettype wire
